sprite_renderer: RTL and testbench



---
 rtl/sprite_if.sv | 29 ++
 rtl/sprite_renderer.sv | 97 +++++++++
 tb/tb_sprite_renderer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_if.sv
// Scan-path bus for sprite_renderer: scan position, sprite placement and animation
// controls, the async sprite ROM port, and the registered pixel outputs.
interface sprite_if #(
  parameter int ADDR_W = 12
);
  logic [9:0]        x;
  logic [8:0]        y;
  logic [9:0]        posx;
  logic [8:0]        posy;
  logic              isplay;
  logic              frame_tick;
  logic              anim_en;
  logic              flip;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       color;
  logic              is_display;
  logic [3:0]        frame_idx;

  modport master (
    output x, y, posx, posy, isplay, frame_tick, anim_en, flip, rom_data,
    input  rom_addr, color, is_display, frame_idx
  );

  modport slave (
    input  x, y, posx, posy, isplay, frame_tick, anim_en, flip, rom_data,
    output rom_addr, color, is_display, frame_idx
  );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite pixel source: box hit test, ROM addressing, transparency keying and frame animation.
// Optional horizontal mirroring is compiled in with `define SPRITE_FLIP_EN.
module sprite_renderer #(
  parameter int          W         = 16,
  parameter int          H         = 16,
  parameter int          FRAMES    = 4,
  parameter int          FRAME_DIV = 8,
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] TRANSP    = 16'h0000,
  parameter logic [15:0] BG        = 16'hffff
) (
  input  logic     clk,
  input  logic     rst_n,
  sprite_if.slave  bus
);

  localparam int FRAME_SZ = W * H;

  logic [10:0]       x_end_s;
  logic [9:0]        y_end_s;
  logic              hit_s;
  logic [9:0]        col_s;
  logic [8:0]        row_s;
  logic [ADDR_W-1:0] addr_s;

  logic              hit1_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [15:0]       color_r;
  logic              is_display_r;
  logic [7:0]        tick_cnt_r;
  logic [3:0]        frame_idx_r;

  // Stage 0: widened box compare so posx+W / posy+H never wrap, then ROM address.
  always_comb begin
    x_end_s = {1'b0, bus.posx} + 11'(W);
    y_end_s = {1'b0, bus.posy} + 10'(H);
    hit_s   = bus.isplay
            & (bus.x >= bus.posx) & ({1'b0, bus.x} < x_end_s)
            & (bus.y >= bus.posy) & ({1'b0, bus.y} < y_end_s);
    row_s   = bus.y - bus.posy;
`ifdef SPRITE_FLIP_EN
    if (bus.flip) begin
      col_s = 10'(W - 1) - (bus.x - bus.posx);
    end else begin
      col_s = bus.x - bus.posx;
    end
`else
    col_s   = bus.x - bus.posx;
`endif
    addr_s  = ADDR_W'(32'(frame_idx_r) * 32'(FRAME_SZ) + 32'(row_s) * 32'(W) + 32'(col_s));
  end

  // Stages 1 and 2: register the address, then key the returned ROM colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit1_r       <= 1'b0;
      rom_addr_r   <= {ADDR_W{1'b0}};
      color_r      <= BG;
      is_display_r <= 1'b0;
    end else begin
      hit1_r     <= hit_s;
      rom_addr_r <= hit_s ? addr_s : {ADDR_W{1'b0}};
      if (hit1_r && (bus.rom_data != TRANSP)) begin
        color_r      <= bus.rom_data;
        is_display_r <= 1'b1;
      end else begin
        color_r      <= BG;
        is_display_r <= 1'b0;
      end
    end
  end

  // Animation: advance one frame every FRAME_DIV enabled ticks; anim_en low holds state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_r  <= 8'd0;
      frame_idx_r <= 4'd0;
    end else if (bus.frame_tick && bus.anim_en) begin
      if (tick_cnt_r == 8'(FRAME_DIV - 1)) begin
        tick_cnt_r  <= 8'd0;
        frame_idx_r <= (frame_idx_r == 4'(FRAMES - 1)) ? 4'd0 : frame_idx_r + 4'd1;
      end else begin
        tick_cnt_r  <= tick_cnt_r + 8'd1;
        frame_idx_r <= frame_idx_r;
      end
    end else begin
      tick_cnt_r  <= tick_cnt_r;
      frame_idx_r <= frame_idx_r;
    end
  end

  assign bus.rom_addr   = rom_addr_r;
  assign bus.color      = color_r;
  assign bus.is_display = is_display_r;
  assign bus.frame_idx  = frame_idx_r;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: directed edge/transparency/animation/flip cases
// plus a randomized scan run compared every cycle against a pixel-level reference model.
module tb_sprite_renderer;

  localparam int          W         = 16;
  localparam int          H         = 16;
  localparam int          FRAMES    = 4;
  localparam int          FRAME_DIV = 2;
  localparam int          ADDR_W    = 12;
  localparam logic [15:0] TRANSP    = 16'h0000;
  localparam logic [15:0] BG        = 16'hffff;
  localparam logic [15:0] GREEN     = 16'h07e0;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sprite_if #(.ADDR_W(ADDR_W)) bus ();

  sprite_renderer #(
    .W(W), .H(H), .FRAMES(FRAMES), .FRAME_DIV(FRAME_DIV), .ADDR_W(ADDR_W),
    .TRANSP(TRANSP), .BG(BG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  assign bus.rom_data = mem[bus.rom_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                m_ticks  = 0;
  bit                m_hit    = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [15:0]       m_color  = BG;
  bit                m_disp   = 1'b0;
  bit                model_ok = 1'b0;

  function automatic int m_frame();
    return (m_ticks / FRAME_DIV) % FRAMES;
  endfunction

  function automatic bit pix_hit();
    int xi, yi, px, py;
    xi = {22'd0, bus.x};    yi = {23'd0, bus.y};
    px = {22'd0, bus.posx}; py = {23'd0, bus.posy};
    return bus.isplay && xi >= px && xi < px + W && yi >= py && yi < py + H;
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr();
    int col, row;
    col = {22'd0, bus.x} - {22'd0, bus.posx};
    row = {23'd0, bus.y} - {23'd0, bus.posy};
    if (FLIP_ON && bus.flip) col = W - 1 - col;
    return ADDR_W'(m_frame() * W * H + row * W + col);
  endfunction

  always @(posedge clk) begin
    model_ok <= 1'b1;
    if (!rst_n) begin
      m_ticks <= 0;
      m_hit   <= 1'b0;
      m_addr  <= '0;
      m_color <= BG;
      m_disp  <= 1'b0;
    end else begin
      if (m_hit && mem[m_addr] != TRANSP) begin
        m_color <= mem[m_addr];
        m_disp  <= 1'b1;
      end else begin
        m_color <= BG;
        m_disp  <= 1'b0;
      end
      m_hit  <= pix_hit();
      m_addr <= pix_hit() ? pix_addr() : '0;
      if (bus.frame_tick && bus.anim_en) m_ticks <= m_ticks + 1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("rom_addr",   32'(bus.rom_addr),   32'(m_addr));
      check("color",      32'(bus.color),      32'(m_color));
      check("is_display", 32'(bus.is_display), 32'(m_disp));
      check("frame_idx",  32'(bus.frame_idx),  32'(m_frame()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [9:0] xv, input logic [8:0] yv);
    @(negedge clk);
    bus.x = xv;
    bus.y = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    #1;
  endtask

  int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem[a] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
    end
    for (int a = 0; a < 16; a++) mem[a] = GREEN;
    mem[5] = TRANSP;

    bus.x = 10'd105; bus.y = 9'd50; bus.posx = 10'd100; bus.posy = 9'd50;
    bus.isplay = 1'b1; bus.flip = 1'b0; bus.anim_en = 1'b1; bus.frame_tick = 1'b1;

    // Reset held 3 clocks with hit stimulus and a coincident frame_tick.
    repeat (3) @(posedge clk);
    #1;
    check("rst_color",     32'(bus.color),      32'h0000ffff);
    check("rst_disp",      32'(bus.is_display), 32'd0);
    check("rst_frame",     32'(bus.frame_idx),  32'd0);
    check("rst_rom_addr",  32'(bus.rom_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.frame_tick = 1'b0;

    // Box edge sweep with transparency hole at x=105.
    for (int xv = 99; xv <= 117; xv++) begin
      int  px;
      bit  ed;
      step(10'(xv), 9'd50);
      check("sweep_addr", 32'(bus.rom_addr), (xv >= 100 && xv <= 115) ? 32'(xv - 100) : 32'd0);
      px = xv - 1;
      if (px >= 99) begin
        ed = (px >= 100 && px <= 115 && px != 105);
        check("sweep_disp",  32'(bus.is_display), 32'(ed));
        check("sweep_color", 32'(bus.color), ed ? 32'(GREEN) : 32'(BG));
      end
    end

    // Mirroring.
    bus.flip = 1'b1;
    step(10'd100, 9'd50);
    check("flip_left",  32'(bus.rom_addr), FLIP_ON ? 32'd15 : 32'd0);
    step(10'd115, 9'd50);
    check("flip_right", 32'(bus.rom_addr), FLIP_ON ? 32'd0 : 32'd15);
    bus.flip = 1'b0;

    // Right-edge wrap guard and isplay gating.
    bus.posx = 10'd1020;
    step(10'd3, 9'd50);
    check("wrap_addr", 32'(bus.rom_addr), 32'd0);
    step(10'd1021, 9'd50);
    check("wrap_disp", 32'(bus.is_display), 32'd0);
    check("edge_addr", 32'(bus.rom_addr), 32'd1);
    bus.posx = 10'd100;
    bus.isplay = 1'b0;
    step(10'd104, 9'd50);
    step(10'd104, 9'd50);
    check("isplay_disp", 32'(bus.is_display), 32'd0);

    // Animation sequence, hold with anim_en low, then addressing at frame 2.
    for (int k = 0; k < 9; k++) begin
      check("anim_seq", 32'(bus.frame_idx), 32'(seq[k]));
      tick();
    end
    check("anim_wrap", 32'(bus.frame_idx), 32'd0);
    bus.anim_en = 1'b0;
    repeat (3) tick();
    check("anim_hold", 32'(bus.frame_idx), 32'd0);
    bus.anim_en = 1'b1;
    repeat (3) tick();
    check("anim_f2", 32'(bus.frame_idx), 32'd2);
    bus.isplay = 1'b1;
    step(10'd100, 9'd50);
    check("f2_addr", 32'(bus.rom_addr), 32'd512);

    // Randomized scan, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) begin
        bus.posx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1010, 1023)) : 10'($urandom);
        bus.posy = 9'($urandom);
        bus.flip = 1'($urandom);
      end
      rst_n          = ($urandom_range(0, 299) != 0);
      bus.isplay     = ($urandom_range(0, 9) != 0);
      bus.anim_en    = ($urandom_range(0, 3) != 0);
      bus.frame_tick = ($urandom_range(0, 5) == 0);
      bus.x = bus.posx + 10'($urandom_range(0, W + 3)) - 10'd2;
      bus.y = bus.posy + 9'($urandom_range(0, H + 3)) - 9'd2;
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
